// File: rtl/mem_ctrl_fsm.sv
// Addressed register-file memory with a request/commit/done control FSM and a
// configurable access wait. Define PARITY_EN for per-word even parity with an inject hook.
module mem_ctrl_fsm #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int WAIT_CYC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              select,
   input  logic              op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef PARITY_EN
   input  logic              par_inj,
   output logic              perr,
`endif
   output logic              ready,
   output logic              rw,
   output logic              valid,
   output logic [DATA_W-1:0] rdata
);

   // state    | meaning
   // S_IDLE   | ready for a request; select captures op/addr/wdata
   // S_ACCESS | waiting out the counter; commit on the edge where it is 0
   // S_DONE   | one-cycle completion, valid high
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [3:0]        cnt;
   logic              op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              accept;
   logic              commit;

   assign accept = (state == S_IDLE) && select;
   assign commit = (state == S_ACCESS) && (cnt == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (select) state_nxt = S_ACCESS;
         S_ACCESS: if (cnt == 4'd0) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // rw follows the captured op for the whole ACCESS/DONE span and drops in IDLE
   always_comb begin
      ready = 1'b0;
      valid = 1'b0;
      rw    = 1'b0;
      case (state)
         S_IDLE:   ready = 1'b1;
         S_ACCESS: rw    = op_q;
         S_DONE: begin
            valid = 1'b1;
            rw    = op_q;
         end
         default:  ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt     <= 4'd0;
      end else if (accept) begin
         op_q    <= op;
         addr_q  <= addr;
         wdata_q <= wdata;
         cnt     <= 4'(WAIT_CYC);
      end else if ((state == S_ACCESS) && (cnt != 4'd0)) begin
         cnt <= cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (commit && op_q) begin
         mem[addr_q] <= wdata_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (commit && !op_q) begin
         rdata <= mem[addr_q];
      end
   end

`ifdef PARITY_EN
   logic             inj_q;
   logic [DEPTH-1:0] mem_par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inj_q <= 1'b0;
      end else if (accept) begin
         inj_q <= par_inj;
      end
   end

   // Stored bit makes data+parity even; inject flips it to force a read error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_par <= '0;
      end else if (commit && op_q) begin
         mem_par[addr_q] <= (^wdata_q) ^ inj_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr <= 1'b0;
      end else if (commit && !op_q) begin
         perr <= (^mem[addr_q]) ^ mem_par[addr_q];
      end
   end
`endif

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Bench for mem_ctrl_fsm: one instance with WAIT_CYC=0 (u0) and one with WAIT_CYC=4 (u1).
module tb_mem_ctrl_fsm;

   logic       clk;
   logic       rst_n;
   logic       sel0, op0, sel1, op1;
   logic [2:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       ready0, rw0, valid0, ready1, rw1, valid1;
   logic [7:0] rdata0, rdata1;
`ifdef PARITY_EN
   logic       inj0, inj1, perr0, perr1;
`endif

   mem_ctrl_fsm #(.DATA_W(8), .ADDR_W(3), .WAIT_CYC(0)) u0 (
      .clk(clk), .rst_n(rst_n), .select(sel0), .op(op0), .addr(addr0), .wdata(wdata0),
`ifdef PARITY_EN
      .par_inj(inj0), .perr(perr0),
`endif
      .ready(ready0), .rw(rw0), .valid(valid0), .rdata(rdata0));

   mem_ctrl_fsm #(.DATA_W(8), .ADDR_W(3), .WAIT_CYC(4)) u1 (
      .clk(clk), .rst_n(rst_n), .select(sel1), .op(op1), .addr(addr1), .wdata(wdata1),
`ifdef PARITY_EN
      .par_inj(inj1), .perr(perr1),
`endif
      .ready(ready1), .rw(rw1), .valid(valid1), .rdata(rdata1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // transaction-level reference: array contents and last read value per instance
   logic [7:0] mdl0 [8];
   logic [7:0] mdl1 [8];
   logic [7:0] rdm0, rdm1;

   typedef struct {
      logic       op;
      logic [2:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rd;
   } vec_t;
   vec_t vt [8];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
      end
   endtask

   function automatic logic rdy(input int u);
      return (u == 0) ? ready0 : ready1;
   endfunction
   function automatic logic vld(input int u);
      return (u == 0) ? valid0 : valid1;
   endfunction
   function automatic logic rwo(input int u);
      return (u == 0) ? rw0 : rw1;
   endfunction
   function automatic logic [7:0] rdo(input int u);
      return (u == 0) ? rdata0 : rdata1;
   endfunction

   task automatic drive(input int u, input logic s, input logic o, input logic [2:0] a,
                        input logic [7:0] d, input logic inj);
      if (u == 0) begin
         sel0 = s; op0 = o; addr0 = a; wdata0 = d;
`ifdef PARITY_EN
         inj0 = inj;
`endif
      end else begin
         sel1 = s; op1 = o; addr1 = a; wdata1 = d;
`ifdef PARITY_EN
         inj1 = inj;
`endif
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         mdl0[i] = 8'h00;
         mdl1[i] = 8'h00;
      end
      rdm0 = 8'h00;
      rdm1 = 8'h00;
   endtask

   // One request: accept, scramble inputs while busy, measure latency, check completion.
   task automatic txn(input int u, input logic o, input logic [2:0] a, input logic [7:0] d,
                      input logic inj, input logic [7:0] exp_rd, input int exp_lat);
      int  lat;
      bit  seen;
      @(negedge clk);
      for (int i = 0; i < 50 && !rdy(u); i++) @(negedge clk);
      chk("ready_idle", rdy(u), 1);
      drive(u, 1'b1, o, a, d, inj);
      @(posedge clk);
      #1 drive(u, 1'b0, ~o, ~a, ~d, 1'b0);
      @(negedge clk);
      chk("rw_early", rwo(u), o);
      lat  = 1;
      seen = vld(u);
      while (!seen && lat < 40) begin
         @(negedge clk);
         lat++;
         seen = vld(u);
      end
      chk("latency", lat, exp_lat);
      chk("ready_busy", rdy(u), 0);
      chk("rw_done", rwo(u), o);
      chk("rdata", rdo(u), exp_rd);
      @(negedge clk);
      chk("valid_drop", vld(u), 0);
      chk("ready_back", rdy(u), 1);
      chk("rw_drop", rwo(u), 0);
   endtask

   task automatic model_txn(input int u, input logic o, input logic [2:0] a, input logic [7:0] d,
                            output logic [7:0] exp_rd);
      if (u == 0) begin
         if (o) mdl0[a] = d; else rdm0 = mdl0[a];
         exp_rd = rdm0;
      end else begin
         if (o) mdl1[a] = d; else rdm1 = mdl1[a];
         exp_rd = rdm1;
      end
   endtask

   initial begin
      logic [7:0] er;
      logic       o, cur_op;
      logic [2:0] a;
      logic [7:0] d, last_w;
      int         nv, last_v, u;

      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      model_clear();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready0", ready0, 1); chk("rst_valid0", valid0, 0);
      chk("rst_rw0", rw0, 0);       chk("rst_rdata0", rdata0, 0);
      chk("rst_ready1", ready1, 1); chk("rst_rdata1", rdata1, 0);

      vt[0] = '{1'b1, 3'd3, 8'hA5, 8'h00};
      vt[1] = '{1'b0, 3'd3, 8'h00, 8'hA5};
      vt[2] = '{1'b1, 3'd0, 8'h11, 8'hA5};
      vt[3] = '{1'b0, 3'd0, 8'h00, 8'h11};
      vt[4] = '{1'b0, 3'd1, 8'h00, 8'h00};
      vt[5] = '{1'b1, 3'd1, 8'h7E, 8'h00};
      vt[6] = '{1'b0, 3'd1, 8'h00, 8'h7E};
      vt[7] = '{1'b0, 3'd3, 8'h00, 8'hA5};
      for (int i = 0; i < 8; i++) begin
         model_txn(0, vt[i].op, vt[i].addr, vt[i].wdata, er);
         txn(0, vt[i].op, vt[i].addr, vt[i].wdata, 1'b0, vt[i].exp_rd, 2);
      end

      // select pulsed while a write is in flight must be dropped
      @(negedge clk);
      drive(0, 1, 1, 3'd5, 8'h3C, 0);
      @(posedge clk);
      #1 drive(0, 1, 1, 3'd6, 8'hFF, 0);
      @(negedge clk);
      @(negedge clk);
      chk("busy_valid", valid0, 1);
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0);
      mdl0[5] = 8'h3C;
      model_txn(0, 0, 3'd6, 0, er);
      txn(0, 0, 3'd6, 0, 0, 8'h00, 2);
      model_txn(0, 0, 3'd5, 0, er);
      txn(0, 0, 3'd5, 0, 0, 8'h3C, 2);

      // back-to-back with held select, alternating write/read on addr 7
      @(negedge clk);
      cur_op = 1'b1; last_w = 8'h00;
      drive(0, 1, 1, 3'd7, 8'h21, 0);
      nv = 0; last_v = 0;
      for (int i = 0; i < 40 && nv < 6; i++) begin
         @(negedge clk);
         if (valid0) begin
            if (nv > 0) chk("b2b_spacing", cyc - last_v, 3);
            last_v = cyc;
            if (cur_op) last_w = wdata0;
            else chk("b2b_rdata", rdata0, last_w);
            nv++;
            cur_op = ~cur_op;
            drive(0, 1, cur_op, 3'd7, wdata0 + 8'h11, 0);
         end
      end
      chk("b2b_count", nv, 6);
      drive(0, 0, 0, 0, 0, 0);
      mdl0[7] = last_w;
      rdm0    = last_w;

      // WAIT_CYC=4 instance: valid after edge k+5, ready back at k+6
      model_txn(1, 1, 3'd4, 8'hC3, er);
      txn(1, 1, 3'd4, 8'hC3, 0, er, 6);
      model_txn(1, 0, 3'd4, 0, er);
      txn(1, 0, 3'd4, 0, 0, 8'hC3, 6);

      // reset in the middle of a WAIT_CYC=4 write
      @(negedge clk);
      drive(1, 1, 1, 3'd2, 8'h5A, 0);
      @(posedge clk);
      #1 drive(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", ready1, 1); chk("mid_rst_valid", valid1, 0);
      chk("mid_rst_rw", rw1, 0);       chk("mid_rst_rdata1", rdata1, 0);
      chk("mid_rst_rdata0", rdata0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      txn(1, 0, 3'd2, 0, 0, 8'h00, 6);
      txn(0, 0, 3'd7, 0, 0, 8'h00, 2);
      txn(0, 0, 3'd3, 0, 0, 8'h00, 2);

      for (int i = 0; i < 40; i++) begin
         u = i % 2;
         o = 1'($urandom_range(0, 1));
         a = 3'($urandom_range(0, 7));
         d = 8'($urandom_range(0, 255));
         model_txn(u, o, a, d, er);
         txn(u, o, a, d, 0, er, (u == 0) ? 2 : 6);
`ifdef PARITY_EN
         if (!o) chk("perr_clean", (u == 0) ? perr0 : perr1, 0);
`endif
      end

`ifdef PARITY_EN
      model_txn(0, 1, 3'd2, 8'h81, er);
      txn(0, 1, 3'd2, 8'h81, 1, er, 2);
      model_txn(0, 0, 3'd2, 0, er);
      txn(0, 0, 3'd2, 0, 0, 8'h81, 2);
      chk("perr_inj", perr0, 1);
      model_txn(0, 1, 3'd2, 8'h81, er);
      txn(0, 1, 3'd2, 8'h81, 0, er, 2);
      chk("perr_hold", perr0, 1);
      model_txn(0, 0, 3'd2, 0, er);
      txn(0, 0, 3'd2, 0, 0, 8'h81, 2);
      chk("perr_clear", perr0, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
